// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_t        - handshake FSM states (IDLE / WAIT / RESP)
//   CNT_W               - width of the wait-state counter
//   DEF_TESTPORT_ADDR   - default byte address of the test-result register
//   DEF_PASS_SIGNATURE  - default value that marks a test as passed
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int CNT_W = 4;

    localparam logic [31:0] DEF_TESTPORT_ADDR  = 32'hFFFF_FFF0;
    localparam logic [31:0] DEF_PASS_SIGNATURE = 32'h0000_0015;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^ADDR_BITS x 32-bit word RAM.
//   clk    in   rising-edge clock
//   we     in   write strobe, sampled at the rising edge
//   addr   in   word index, shared by the write and read ports
//   wdata  in   write data
//   wbe    in   byte-lane enables; bit i writes wdata[8i+7:8i]
//   rdata  out  combinational read of the word at addr
// Contents are never cleared; a reset of the responder leaves them intact.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wbe,
    output logic [31:0]          rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [31:0] mem [0:DEPTH-1];

    // Byte-lane write: only the enabled lanes of the addressed word change,
    // so a store with wbe == 0 completes without touching the array.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read is combinational; the responder registers it at the commit edge.
    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the core's memread/memwrite/dataadr/writedata
// load/store bus, with a configurable number of wait states per access.
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   memread    in   load request, held with dataadr until memready
//   memwrite   in   store request, held with dataadr/writedata/byteen until memready
//   dataadr    in   byte address
//   writedata  in   store data
//   byteen     in   store byte lanes
//   readdata   out  load data, registered at the commit edge; holds otherwise
//   memready   out  one-cycle completion pulse
//   memerr     out  error status, valid with memready
//   test_done  out  test register written (DMEM_TESTPORT_EN only)
//   test_pass  out  last test-register write matched PASS_SIGNATURE (DMEM_TESTPORT_EN only)
// Optional feature macro: DMEM_TESTPORT_EN enables the memory-mapped test
// register at TESTPORT_ADDR; without it that address is simply out of range.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
`ifdef DMEM_TESTPORT_EN
    ,
    parameter logic [31:0] TESTPORT_ADDR  = DEF_TESTPORT_ADDR,
    parameter logic [31:0] PASS_SIGNATURE = DEF_PASS_SIGNATURE
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteen,
    output logic [31:0] readdata,
    output logic        memready,
    output logic        memerr
`ifdef DMEM_TESTPORT_EN
    ,
    output logic        test_done,
    output logic        test_pass
`endif
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;

    logic [31:0] adrQ;
    logic [31:0] dataQ;
    logic [3:0]  beQ;
    logic        rdQ;
    logic        wrQ;

    logic [31:0] arrayRdata;
    logic        arrayWe;
    logic        misaligned;
    logic        outOfRange;
    logic        conflict;
    logic        tpHit;
    logic        badAddr;
    logic        commit;

    // Request capture. Everything the access needs is latched at the IDLE
    // edge, so the master's bus may change freely until memready.
    always_ff @(posedge clk) begin
        if (state == IDLE && (memread || memwrite)) begin
            adrQ  <= dataadr;
            dataQ <= writedata;
            beQ   <= byteen;
            rdQ   <= memread;
            wrQ   <= memwrite;
        end
    end

    // Access classification on the captured address. The test port sits far
    // above the array, so it is carved out of the out-of-range check.
    // The array write strobe is gated by reset so an aborted access never
    // commits even if reset lands on the commit edge.
    always_comb begin
        misaligned = (adrQ[1:0] != 2'b00);
`ifdef DMEM_TESTPORT_EN
        tpHit      = (adrQ == TESTPORT_ADDR);
`else
        tpHit      = 1'b0;
`endif
        outOfRange = ((adrQ >> (ADDR_BITS + 2)) != 32'd0) && !tpHit;
        conflict   = rdQ && wrQ;
        badAddr    = misaligned || outOfRange;
        commit     = (state == WAIT) && (cnt == '0);
        arrayWe    = commit && !reset && wrQ && !rdQ && !badAddr && !tpHit;
    end

    dmem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (arrayWe),
        .addr  (adrQ[ADDR_BITS+1:2]),
        .wdata (dataQ),
        .wbe   (beQ),
        .rdata (arrayRdata)
    );

    // Handshake FSM with registered outputs. A conflicting request reports
    // an error and leaves readdata alone; a bad address reports an error and
    // a load returns zero. memerr only lives for the RESP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            readdata <= '0;
            memready <= 1'b0;
            memerr   <= 1'b0;
`ifdef DMEM_TESTPORT_EN
            test_done <= 1'b0;
            test_pass <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    memready <= 1'b0;
                    if (memread || memwrite) begin
                        cnt   <= WAIT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        memready <= 1'b1;
                        memerr   <= conflict || badAddr;
                        state    <= RESP;
                        if (!conflict) begin
                            if (badAddr) begin
                                if (rdQ) begin
                                    readdata <= '0;
                                end
                            end else if (rdQ) begin
`ifdef DMEM_TESTPORT_EN
                                readdata <= tpHit ? {30'b0, test_pass, test_done}
                                                  : arrayRdata;
`else
                                readdata <= arrayRdata;
`endif
                            end
`ifdef DMEM_TESTPORT_EN
                            else if (tpHit) begin
                                test_done <= 1'b1;
                                test_pass <= (dataQ == PASS_SIGNATURE);
                            end
`endif
                        end
                    end
                end
                RESP: begin
                    memready <= 1'b0;
                    memerr   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    memready <= 1'b0;
                    memerr   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven bench for dmem_responder.
// dut uses WAIT_CYCLES=2 for the vector table, abort and test-port sequences;
// dut0 uses WAIT_CYCLES=0 for the held-request back-to-back sequence.
// Build with DMEM_TESTPORT_EN defined to exercise the test register.
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    logic        memread, memwrite;
    logic [31:0] dataadr, writedata;
    logic [3:0]  byteen;
    logic [31:0] readdata;
    logic        memready, memerr;

    logic        rd0, wr0;
    logic [31:0] adr0, wd0;
    logic [3:0]  be0;
    logic [31:0] readdata0;
    logic        memready0, memerr0;

`ifdef DMEM_TESTPORT_EN
    logic        test_done, test_pass;
    logic        test_done0, test_pass0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        chk;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(
        .ADDR_BITS   (8),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .byteen    (byteen),
        .readdata  (readdata),
        .memready  (memready),
        .memerr    (memerr)
`ifdef DMEM_TESTPORT_EN
        ,
        .test_done (test_done),
        .test_pass (test_pass)
`endif
    );

    dmem_responder #(
        .ADDR_BITS   (8),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk       (clk),
        .reset     (reset),
        .memread   (rd0),
        .memwrite  (wr0),
        .dataadr   (adr0),
        .writedata (wd0),
        .byteen    (be0),
        .readdata  (readdata0),
        .memready  (memready0),
        .memerr    (memerr0)
`ifdef DMEM_TESTPORT_EN
        ,
        .test_done (test_done0),
        .test_pass (test_pass0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] adr,
                                input logic [31:0] data, input logic [3:0] be,
                                input logic chk, input logic [31:0] expData, input logic expErr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.adr = adr; v.data = data; v.be = be;
        v.chk = chk; v.expData = expData; v.expErr = expErr;
        return v;
    endfunction

    // One access on dut: present the request, count edges after the capture
    // edge until memready, then drop the request and confirm the pulse and
    // memerr last exactly one cycle.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] adr,
                                 input logic [31:0] data, input logic [3:0] be,
                                 output logic [31:0] rdOut, output logic errOut,
                                 output int edges);
        @(negedge clk);
        memread = rd; memwrite = wr; dataadr = adr; writedata = data; byteen = be;
        @(posedge clk);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!memready && edges < 40);
        rdOut  = readdata;
        errOut = memerr;
        memread = 1'b0; memwrite = 1'b0;
        if (!memready) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout waiting for memready at adr %h", adr);
        end else begin
            @(posedge clk);
            #1;
            checkOutput("pulseWidth", {31'b0, memready}, 32'd0);
            checkOutput("errCleared", {31'b0, memerr}, 32'd0);
        end
    endtask

    // Held-request burst on dut0 (no wait states): four accesses to
    // 0x40..0x4C, advancing address/data in each RESP cycle; pulses must
    // arrive every third edge, the first two edges after raising the request.
    task automatic runBurst(input logic isRead);
        int t, lastT, pulses;
        @(negedge clk);
        @(negedge clk);
        rd0 = isRead; wr0 = !isRead; adr0 = 32'h40; wd0 = 32'hA0; be0 = 4'hF;
        t = 0; lastT = 0; pulses = 0;
        while (pulses < 4 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
            if (memready0) begin
                checkOutput(pulses == 0 ? "b2bFirstLatency" : "b2bInterval",
                            t - lastT, pulses == 0 ? 32'd2 : 32'd3);
                checkOutput("b2bErr", {31'b0, memerr0}, 32'd0);
                if (isRead) begin
                    checkOutput("b2bReadData", readdata0, 32'hA0 + pulses);
                end
                lastT = t;
                pulses++;
                if (pulses < 4) begin
                    adr0 = 32'h40 + 4 * pulses;
                    wd0  = 32'hA0 + pulses;
                end else begin
                    rd0 = 1'b0; wr0 = 1'b0;
                end
            end
        end
        checkOutput("b2bPulseCount", pulses, 32'd4);
        rd0 = 1'b0; wr0 = 1'b0;
    endtask

    initial begin
        logic [31:0] rdv;
        logic        errv;
        int          edges;
        logic        sawReady;

        memread = 0; memwrite = 0; dataadr = 0; writedata = 0; byteen = 0;
        rd0 = 0; wr0 = 0; adr0 = 0; wd0 = 0; be0 = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetReaddata", readdata, 32'd0);
        checkOutput("resetMemready", {31'b0, memready}, 32'd0);
        checkOutput("resetMemerr", {31'b0, memerr}, 32'd0);
        checkOutput("resetMemready0", {31'b0, memready0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //                rd    wr    adr            data           be     chk   expData        expErr
        vecs.push_back(mk(1'b0, 1'b1, 32'h10,        32'h1111_1111, 4'hF, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h3F0,       32'h2222_2222, 4'hF, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'd84,        32'd7,         4'hF, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'd84,        32'h0,         4'h0, 1'b1, 32'd7,         1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h14,        32'h5500_00FF, 4'hF, 1'b1, 32'd7,         1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h14,        32'hAAAA_AAAA, 4'h2, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h14,        32'h0,         4'h0, 1'b1, 32'h5500_AAFF, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h2C,        32'h33,        4'hF, 1'b0, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h12,        32'd2,         4'hF, 1'b0, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 32'h70F0_0FF0, 32'd2,         4'hF, 1'b0, 32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h70F0_0FF0, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h10,        32'h0,         4'h0, 1'b1, 32'h1111_1111, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h3F0,       32'h0,         4'h0, 1'b1, 32'h2222_2222, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h14,        32'h0,         4'h0, 1'b1, 32'h5500_AAFF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 32'h14,        32'h0,         4'hF, 1'b1, 32'h5500_AAFF, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h14,        32'h0,         4'h0, 1'b1, 32'h5500_AAFF, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h14,        32'h0,         4'h0, 1'b1, 32'h5500_AAFF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h14,        32'h0,         4'h0, 1'b1, 32'h5500_AAFF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h15,        32'h0,         4'h0, 1'b1, 32'h0,         1'b1));
`ifndef DMEM_TESTPORT_EN
        vecs.push_back(mk(1'b1, 1'b0, 32'd84,        32'h0,         4'h0, 1'b1, 32'd7,         1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h15,        4'hF, 1'b1, 32'd7,         1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,         4'h0, 1'b1, 32'h0,         1'b1));
`endif
        vecs.push_back(mk(1'b1, 1'b0, 32'd84,        32'h0,         4'h0, 1'b1, 32'd7,         1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].data, vecs[i].be,
                          rdv, errv, edges);
            checkOutput($sformatf("v%0d latency", i), edges, 32'd3);
            checkOutput($sformatf("v%0d memerr", i), {31'b0, errv}, {31'b0, vecs[i].expErr});
            if (vecs[i].chk) begin
                checkOutput($sformatf("v%0d readdata", i), rdv, vecs[i].expData);
            end
        end

        // Reset during WAIT: the store of 9 to 0x2C must vanish without a
        // memready, and readdata returns to zero.
        @(negedge clk);
        memwrite = 1'b1; dataadr = 32'h2C; writedata = 32'd9; byteen = 4'hF;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; memwrite = 1'b0;
        checkOutput("abortReaddata", readdata, 32'd0);
        sawReady = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (memready) sawReady = 1'b1;
        end
        checkOutput("abortNoReady", {31'b0, sawReady}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h2C, 32'h0, 4'h0, rdv, errv, edges);
        checkOutput("abortOldData", rdv, 32'h33);
        checkOutput("abortLoadErr", {31'b0, errv}, 32'd0);

        // Back-to-back held requests with no wait states.
        runBurst(1'b0);
        runBurst(1'b1);

`ifdef DMEM_TESTPORT_EN
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h15, 4'hF, rdv, errv, edges);
        checkOutput("tpStoreErr", {31'b0, errv}, 32'd0);
        checkOutput("tpDone", {31'b0, test_done}, 32'd1);
        checkOutput("tpPass", {31'b0, test_pass}, 32'd1);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0, rdv, errv, edges);
        checkOutput("tpLoad", rdv, 32'd3);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h3F8, 4'hF, rdv, errv, edges);
        checkOutput("tpDoneSticky", {31'b0, test_done}, 32'd1);
        checkOutput("tpPassCleared", {31'b0, test_pass}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0, rdv, errv, edges);
        checkOutput("tpLoad2", rdv, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("tpResetDone", {31'b0, test_done}, 32'd0);
        checkOutput("tpResetPass", {31'b0, test_pass}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the MIPS core's load/store bus; it is the memory end of the memwrite/dataadr/writedata interface that the processor drives.
- Accepts one load or store at a time through a ready handshake with a configurable wait-state count.
- Supports byte-enabled stores.
- Flags misaligned, out-of-range and conflicting accesses.
- Lets simulation and FPGA builds model slow memory behind the core.

Parameters:
- ADDR_BITS, 8, word-address bits; array depth is 2^ADDR_BITS 32-bit words.
- WAIT_CYCLES, 2, extra wait states per access (0..15).
- TESTPORT_ADDR, 32'hFFFF_FFF0, byte address of the test-result register (used only with the optional feature).
- PASS_SIGNATURE, 32'h0000_0015, value that marks a test as passed (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- memread  in  1  load request; held with dataadr until memready
- memwrite  in  1  store request; held with dataadr, writedata and byteen until memready
- dataadr  in  32  byte address
- writedata  in  32  store data
- byteen  in  4  store byte lanes; bit i enables writedata[8i+7:8i]
- readdata  out  32  load data; valid while memready is high after a load
- memready  out  1  one-cycle completion pulse
- memerr  out  1  error status, valid with memready
- test_done  out  1  optional feature only
- test_pass  out  1  optional feature only

Behaviour:
- Reset: synchronous and active-high, taking effect at the next rising clk edge.
  - Outputs: readdata=0, memready=0, memerr=0, test_done=0, test_pass=0.
  - FSM goes to IDLE and the wait counter to 0.
  - Array contents are not cleared.
- Reset mid-access: the access is aborted, no write is committed, and no memready is produced.
- FSM states are IDLE, WAIT and RESP.
  - IDLE: at an edge with memread or memwrite high, capture address, data, byteen and request type; load cnt=WAIT_CYCLES; go to WAIT.
  - WAIT: at an edge with cnt>0, decrement cnt. At an edge with cnt==0, commit the access, set memready=1 and memerr as below, and go to RESP.
  - RESP: memready is high for exactly this cycle. At the next edge, memready=0 and the FSM returns to IDLE.
  - A request still asserted in IDLE after RESP is treated as a new access.
- Latency: memready is high in the cycle following the (WAIT_CYCLES+1)-th edge after the capture edge. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Captured values are used throughout; input changes after the capture edge are ignored.
- Word index is adr[ADDR_BITS+1:2].
- Store commit writes only the lanes enabled in byteen. byteen=4'b0000 completes with no change.
- Load commit registers the array word into readdata. readdata holds until the next load commit or reset; stores do not change it.
- Error cases:
  - Misaligned (adr[1:0]!=0): memerr=1; no write; a load returns readdata=0.
  - Out of range (adr[31:ADDR_BITS+2]!=0 and not the test port): memerr=1; no write; a load returns readdata=0.
  - memread and memwrite both high at capture: memerr=1; no write; readdata unchanged.
- memerr is cleared to 0 at the RESP->IDLE edge.

Optional Feature:
- Macro: DMEM_TESTPORT_EN.
- When defined:
  - test_done and test_pass ports exist.
  - An aligned store to TESTPORT_ADDR is committed to the test register, not the array, with memerr=0.
  - On that commit, test_done<=1 and test_pass<=(writedata==PASS_SIGNATURE), both sticky until reset. A later test-port store overwrites test_pass.
  - A load from TESTPORT_ADDR returns {30'b0, test_pass, test_done}.
- When undefined:
  - No test-port ports or logic.
  - TESTPORT_ADDR is an ordinary out-of-range address.

Decomposition:
- Package dmem_pkg holds:
  - FSM state typedef (IDLE/WAIT/RESP);
  - WAIT counter width constant (4);
  - default TESTPORT_ADDR and PASS_SIGNATURE constants.
- Sub-module dmem_array: 2^ADDR_BITS x 32 RAM with a synchronous byte-lane write and a read port. The FSM, address checks and test port live in dmem_responder.

Test Plan:
- Basic store then load, WAIT_CYCLES=2:
  - Store 7 to address 84, byteen=4'hF; then load address 84.
  - memready pulses 3 edges after each capture; readdata=7; memerr=0.
- Byte-lane store:
  - Store 32'h550000FF to 0x14, then store 32'hAAAA_AAAA to 0x14 with byteen=4'b0010; load 0x14.
  - readdata=32'h5500AAFF.
- Misaligned and out-of-range accesses:
  - Store 2 to 0x12: memerr=1.
  - Store 2 to 0x70F00FF0: memerr=1.
  - Load 0x70F00FF0: readdata=0, memerr=1.
  - No array word changed.
- Conflict and reset mid-access:
  - memread and memwrite both high: memerr=1, readdata unchanged.
  - Store 9 to 0x2C with reset asserted during WAIT: no memready; a later load of 0x2C returns the prior contents.
- WAIT_CYCLES=0 with back-to-back requests held high:
  - memready is high every 3rd cycle.
  - No request is lost or duplicated.
- DMEM_TESTPORT_EN:
  - Store 32'h15 to 0xFFFFFFF0: test_done=1, test_pass=1.
  - Then store 32'h3F8 to 0xFFFFFFF0: test_pass=0.
  - Then assert reset: test_done=0, test_pass=0.
